// File: rtl/ws2812_pkg.sv
// Shared constants and state encoding for the WS2812B string serializer.
// Timing defaults assume a 100 MHz clock.
package ws2812_pkg;

  localparam int unsigned PIXEL_W   = 24;
  localparam int unsigned T0H_CYC   = 40;
  localparam int unsigned T0L_CYC   = 85;
  localparam int unsigned T1H_CYC   = 80;
  localparam int unsigned T1L_CYC   = 45;
  localparam int unsigned LATCH_CYC = 6000;
  localparam int unsigned TIMER_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } ws_state_e;

endpackage

// File: rtl/ws2812_serializer.sv
// WS2812B transmitter: serializes 24-bit pixels MSB first as NRZ pulse-width bits
// and inserts the latch gap after the last pixel of a frame.
module ws2812_serializer #(
  parameter int unsigned T0H_CYC   = ws2812_pkg::T0H_CYC,
  parameter int unsigned T0L_CYC   = ws2812_pkg::T0L_CYC,
  parameter int unsigned T1H_CYC   = ws2812_pkg::T1H_CYC,
  parameter int unsigned T1L_CYC   = ws2812_pkg::T1L_CYC,
  parameter int unsigned LATCH_CYC = ws2812_pkg::LATCH_CYC,
  parameter int unsigned TIMER_W   = ws2812_pkg::TIMER_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        sdi,
  output logic        busy,
  output logic        underrun
);

  import ws2812_pkg::*;

  localparam logic [TIMER_W-1:0] T0H_M1   = TIMER_W'(T0H_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] T0L_M1   = TIMER_W'(T0L_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] T1H_M1   = TIMER_W'(T1H_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] T1L_M1   = TIMER_W'(T1L_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] LATCH_M1 = TIMER_W'(LATCH_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] TIMER_0  = {TIMER_W{1'b0}};

  ws_state_e            state_r, next_state_s;
  logic [PIXEL_W-1:0]   shreg_r, shreg_s;
  logic [4:0]           bit_cnt_r, bit_cnt_s;
  logic [TIMER_W-1:0]   timer_r, timer_s;
  logic                 last_r, last_s;
  logic                 sdi_r, underrun_r, underrun_s;
  logic                 timer_done_s, word_end_s, ready_s, xfer_s;

  function automatic logic [TIMER_W-1:0] high_time(input logic bit_val);
    return bit_val ? T1H_M1 : T0H_M1;
  endfunction

  function automatic logic [TIMER_W-1:0] low_time(input logic bit_val);
    return bit_val ? T1L_M1 : T0L_M1;
  endfunction

  assign timer_done_s = (timer_r == TIMER_0);
  assign word_end_s   = (state_r == ST_LOW) && (bit_cnt_r == 5'd23) && timer_done_s;
  // The end of a frame's last pixel never acknowledges a waiting pixel.
  assign ready_s      = (state_r == ST_IDLE) || (word_end_s && !last_r);
  assign xfer_s       = pix_valid && ready_s;

  assign pix_ready = ready_s;
  assign busy      = (state_r != ST_IDLE);
  assign sdi       = sdi_r;
  assign underrun  = underrun_r;

  // Next-state, timer, shift register and bit counter logic.
  always_comb begin
    next_state_s = state_r;
    shreg_s      = shreg_r;
    bit_cnt_s    = bit_cnt_r;
    last_s       = last_r;
    underrun_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      timer_s = timer_r;
    end else begin
      timer_s = timer_r - {{(TIMER_W-1){1'b0}}, 1'b1};
    end

    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          shreg_s      = pix_data;
          last_s       = pix_last;
          bit_cnt_s    = 5'd0;
          timer_s      = high_time(pix_data[23]);
          next_state_s = ST_HIGH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (timer_done_s) begin
          timer_s      = low_time(shreg_r[PIXEL_W-1]);
          next_state_s = ST_LOW;
        end else begin
          next_state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (!timer_done_s) begin
          next_state_s = ST_LOW;
        end else if (bit_cnt_r != 5'd23) begin
          shreg_s      = {shreg_r[PIXEL_W-2:0], 1'b0};
          bit_cnt_s    = bit_cnt_r + 5'd1;
          timer_s      = high_time(shreg_r[PIXEL_W-2]);
          next_state_s = ST_HIGH;
        end else if (last_r) begin
          timer_s      = LATCH_M1;
          next_state_s = ST_LATCH;
        end else if (xfer_s) begin
          shreg_s      = pix_data;
          last_s       = pix_last;
          bit_cnt_s    = 5'd0;
          timer_s      = high_time(pix_data[23]);
          next_state_s = ST_HIGH;
        end else begin
          timer_s      = TIMER_0;
          underrun_s   = 1'b1;
          next_state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (timer_done_s) begin
          timer_s      = TIMER_0;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_LATCH;
        end
      end
      default: begin
        timer_s      = LATCH_M1;
        next_state_s = ST_LATCH;
      end
    endcase
  end

  // State and datapath registers; reset enters a full latch gap with the line low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_LATCH;
      timer_r    <= LATCH_M1;
      shreg_r    <= {PIXEL_W{1'b0}};
      bit_cnt_r  <= 5'd0;
      last_r     <= 1'b0;
      sdi_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      timer_r    <= timer_s;
      shreg_r    <= shreg_s;
      bit_cnt_r  <= bit_cnt_s;
      last_r     <= last_s;
      sdi_r      <= (next_state_s == ST_HIGH);
      underrun_r <= underrun_s;
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Scoreboard bench: the driver queues expected pixels at each handshake, a line
// decoder on sdi rebuilds pixels from pulse widths and compares them in order.
module tb_ws2812_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_last = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, sdi, busy, underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int un_count = 0;
  int un_cyc = -1;
  int last_rise = -1;
  bit strict = 1'b0;

  typedef struct {
    logic [23:0] data;
    int          idx;
  } exp_t;
  exp_t exp_q[$];

  ws2812_serializer dut (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_last(pix_last),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .sdi(sdi), .busy(busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Sends one pixel; xc is the index of the clock edge that accepts it.
  task automatic send(input logic [23:0] d, input bit last, input bit push,
                      input int idx, output int xc);
    int budget;
    budget = 0;
    @(negedge clk);
    pix_data = d; pix_last = last; pix_valid = 1'b1;
    while (!pix_ready && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: pix_ready stayed 0, expected 1 within 20000 cycles");
      pix_valid = 1'b0;
      xc = -1;
    end else begin
      xc = cyc + 1;
      if (push) exp_q.push_back('{data: d, idx: idx});
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at the negedge where rst_n is released.
  task automatic latch_gap_check();
    int bad;
    bad = 0;
    for (int i = 0; i < 6000; i++) begin
      if (pix_ready !== 1'b0 || sdi !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("latch_gap_violations", bad, 0);
    chk("ready_after_gap", pix_ready, 1);
    chk("busy_after_gap", busy, 0);
  endtask

  // Line decoder and scoreboard checker.
  initial begin : decoder
    bit prev; bit lastbit;
    int hi, lo, nb, pidx, prev_rise;
    logic [23:0] sh;
    exp_t e;
    prev = 1'b0; lastbit = 1'b0; hi = 0; lo = 0; nb = 0; pidx = 0; prev_rise = -1; sh = 24'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; hi = 0; lo = 0; nb = 0; pidx = 0; prev_rise = -1;
      end else if (sdi) begin
        if (!prev) begin
          if (nb > 0) chk("low_width", lo, lastbit ? 45 : 85);
          if (strict && prev_rise >= 0) chk("rise_period", cyc - prev_rise, 125);
          prev_rise = cyc;
          last_rise = cyc;
          hi = 1;
        end else begin
          hi++;
        end
        prev = 1'b1;
      end else begin
        if (prev) begin
          lastbit = (hi >= 65 && hi <= 95);
          chk("high_width", hi, lastbit ? 80 : 40);
          sh = {sh[22:0], lastbit};
          nb++;
          lo = 1;
          if (nb == 24) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_pixel: got 0x%06h, expected no pixel", sh);
            end else begin
              e = exp_q.pop_front();
              chk("pixel_data", sh, e.data);
              chk("pixel_index", pidx, e.idx);
            end
            pidx++;
          end
        end else begin
          lo++;
          if (lo == 5000) begin
            nb = 0; pidx = 0; prev_rise = -1;
          end
        end
        prev = 1'b0;
      end
    end
  end

  // Underrun pulse recorder.
  initial begin : underrun_mon
    forever begin
      @(negedge clk);
      if (rst_n && underrun) begin
        un_count++;
        un_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #960000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 96000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int x1, x2, x3, x4, un_before;
    int xs[4];
    logic [23:0] frame3[4];
    frame3[0] = 24'h3C96E1; frame3[1] = 24'h00FF00;
    frame3[2] = 24'hFFFFFF; frame3[3] = 24'h123456;

    // Reset latch gap.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    latch_gap_check();

    // Single-pixel frame, then busy drops exactly at the end of the latch gap.
    send(24'hA5C30F, 1'b1, 1'b1, 0, x1);
    drop_valid();
    wait_cyc(x1 + 8999);
    chk("busy_in_latch", busy, 1);
    wait_cyc(x1 + 9000);
    chk("busy_after_latch", busy, 0);

    // Back-to-back 4-pixel frame.
    un_before = un_count;
    strict = 1'b1;
    for (int i = 0; i < 4; i++) send(frame3[i], (i == 3), 1'b1, i, xs[i]);
    drop_valid();
    for (int i = 1; i < 4; i++) chk("b2b_xfer_spacing", xs[i] - xs[i-1], 3000);
    wait_cyc(xs[3] + 9000);
    strict = 1'b0;
    chk("b2b_no_underrun", un_count - un_before, 0);
    chk("b2b_idle_after", busy, 0);

    // Starvation between two pixels.
    un_before = un_count;
    send(24'h800001, 1'b0, 1'b1, 0, x1);
    drop_valid();
    wait_cyc(x1 + 3020);
    chk("underrun_count", un_count - un_before, 1);
    chk("underrun_cycle", un_cyc, x1 + 3000);
    send(24'h7FFFFE, 1'b1, 1'b1, 1, x2);
    drop_valid();
    repeat (5) @(negedge clk);
    chk("restart_rise", last_rise, x2);
    wait_cyc(x2 + 9001);

    // Pixel presented early after a frame's last pixel waits out the latch gap.
    send(24'hDEADBE, 1'b0, 1'b1, 0, x1);
    send(24'h0FF00F, 1'b1, 1'b1, 1, x2);
    send(24'hC0FFEE, 1'b0, 1'b1, 0, x3);
    chk("early_pixel_held", x3 - x2, 9001);

    // Reset in the middle of bit 10 of an aborted pixel.
    send(24'hAA55AA, 1'b0, 1'b0, 1, x4);
    wait_cyc(x4 + 1260);
    pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_sdi", sdi, 0);
    chk("reset_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    latch_gap_check();
    send(24'h5A5A5A, 1'b0, 1'b1, 0, x1);
    drop_valid();
    wait_cyc(x1 + 3002);
    chk("final_underrun_cycle", un_cyc, x1 + 3000);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
